// File: rtl/eq_serial_ctrl.sv
// -----------------------------------------------------------------------------
// eq_serial_ctrl
//
// Bit-serial word comparator controller. It drives one external 1-bit
// equality cell (s = ~(x ^ y)) with one bit-pair per clock, LSB first. It
// folds the returned s bits into a word-level equal flag and reports the
// result with a one-cycle done pulse. One small cell can therefore compare
// operands of any width.
//
// Parameters:
//   WIDTH  operand width in bits (1..64)
//
// Ports:
//   clk    system clock, rising edge
//   rst    asynchronous active-high reset
//   start  comparison request, only sampled while idle
//   a, b   operands, captured on the edge that accepts start
//   eq_x   bit of A presented to the cell's x input
//   eq_y   bit of B presented to the cell's y input
//   eq_s   cell result for the current eq_x/eq_y pair
//   busy   high while a comparison is in flight (SHIFT or DONE)
//   done   one-cycle pulse when equal is valid
//   equal  result, 1 when a == b; held until the next accepted start
//
// Build option:
//   EQ_SERIAL_EARLY_EXIT_EN  when defined, the first mismatching bit ends
//                            the comparison immediately instead of
//                            scanning all WIDTH bits.
// -----------------------------------------------------------------------------
module eq_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             eq_x,
    output logic             eq_y,
    input  logic             eq_s,
    output logic             busy,
    output logic             done,
    output logic             equal
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [CW-1:0]    cnt;
    logic             acc;
    logic             finish;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and outputs. eq_x/eq_y come only from the shift registers,
    // so nothing combinational leaks from a/b to the cell.
    always_comb begin
        state_nxt = state;
        eq_x      = 1'b0;
        eq_y      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                eq_x = sa[0];
                eq_y = sb[0];
`ifdef EQ_SERIAL_EARLY_EXIT_EN
                // A single mismatch already decides the result.
                finish = (cnt == CW'(WIDTH - 1)) || !eq_s;
`else
                finish = (cnt == CW'(WIDTH - 1));
`endif
                if (finish) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand shifters, bit counter and result accumulation. eq_s is only
    // looked at in SHIFT, so junk on it at other times cannot reach equal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa    <= '0;
            sb    <= '0;
            cnt   <= '0;
            acc   <= 1'b1;
            equal <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        cnt   <= '0;
                        acc   <= 1'b1;
                        equal <= 1'b0;
                    end
                end
                SHIFT: begin
                    acc <= acc & eq_s;
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    cnt <= cnt + CW'(1);
                    if (finish) begin
                        equal <= acc & eq_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eq_serial_ctrl.sv
module tb_eq_serial_ctrl;

    localparam int W = 8;
`ifdef EQ_SERIAL_EARLY_EXIT_EN
    localparam int LSB_LAT = 1;
`else
    localparam int LSB_LAT = 8;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         eq_x;
    logic         eq_y;
    logic         eq_s;
    logic         busy;
    logic         done;
    logic         equal;

    // junk injected on eq_s whenever the reference says no bit is in flight
    logic         noise = 1'b0;
    logic         noise_gate = 1'b0;

    int n_chk = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    // the external 1-bit equality cell
    assign eq_s = ~(eq_x ^ eq_y) ^ (noise & noise_gate);

    eq_serial_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a_i),
        .b     (b_i),
        .eq_x  (eq_x),
        .eq_y  (eq_y),
        .eq_s  (eq_s),
        .busy  (busy),
        .done  (done),
        .equal (equal)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Number of edges after the accept edge until done is shown.
    function automatic int calc_lat(input logic [W-1:0] av, input logic [W-1:0] bv);
`ifdef EQ_SERIAL_EARLY_EXIT_EN
        for (int k = 0; k < W; k++)
            if (av[k] != bv[k]) return k + 1;
`endif
        return W;
    endfunction

    // Reference: m_j = edges since acceptance (-1 when idle).
    int           m_j = -1;
    int           m_lat = W;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    logic         m_equal = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_j     = -1;
            m_equal = 1'b0;
        end else if (m_j < 0) begin
            if (start) begin
                m_a     = a_i;
                m_b     = b_i;
                m_lat   = calc_lat(a_i, b_i);
                m_j     = 0;
                m_equal = 1'b0;
            end
        end else if (m_j == m_lat) begin
            m_j = -1;
        end else begin
            m_j++;
            if (m_j == m_lat) m_equal = (m_a == m_b);
        end
    end

    // Compare process plus noise scheduling for the coming cycle.
    always @(negedge clk) begin
        bit   sh;
        logic ex;
        logic ey;
        sh = (m_j >= 0) && (m_j < m_lat);
        ex = sh ? m_a[m_j] : 1'b0;
        ey = sh ? m_b[m_j] : 1'b0;
        if (cmp_en) begin
            check("busy",  busy,  (m_j >= 0));
            check("done",  done,  (m_j >= 0) && (m_j == m_lat));
            check("equal", equal, m_equal);
            check("eq_x",  eq_x,  ex);
            check("eq_y",  eq_y,  ey);
        end
        noise_gate = !sh;
        noise      = 1'($urandom_range(0, 1));
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 1, 0);
    endtask

    // Starts a comparison, scrambles a/b (and optionally start) while busy,
    // measures latency to done and checks the result.
    task automatic run_cmp(input logic [W-1:0] av, input logic [W-1:0] bv,
                           input int exp_lat, input logic exp_eq,
                           input bit noisy_start, input string nm);
        int lat = 0;
        wait_idle();
        start = 1'b1;
        a_i   = av;
        b_i   = bv;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        while (!done && lat < 40) begin
            a_i   = W'($urandom);
            b_i   = W'($urandom);
            start = noisy_start ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        start = 1'b0;
        check({nm, "_lat"},   lat,   exp_lat);
        check({nm, "_equal"}, equal, exp_eq);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int  n;
        int  lat;
        bit  seen_low;
        bit  seen_done;
        logic [W-1:0] av;
        logic [W-1:0] bv;

        rst   = 1'b1;
        start = 1'b0;
        a_i   = '0;
        b_i   = '0;
        #1;
        check("rst_busy",  busy,  0);
        check("rst_done",  done,  0);
        check("rst_equal", equal, 0);
        check("rst_eq_x",  eq_x,  0);
        check("rst_eq_y",  eq_y,  0);
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        cmp_en = 1'b1;

        // directed cases with literal expectations
        run_cmp(8'hA5, 8'hA5, 8, 1'b1, 1'b0, "a5");
        repeat (5) @(negedge clk);
        check("a5_hold_equal", equal, 1);
        run_cmp(8'h80, 8'h00, 8, 1'b0, 1'b0, "msb");
        run_cmp(8'h01, 8'h00, LSB_LAT, 1'b0, 1'b0, "lsb");

        // start held high across two back-to-back comparisons
        wait_idle();
        start = 1'b1;
        a_i   = 8'h3C;
        b_i   = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        a_i       = 8'hFF;
        b_i       = 8'hFE;
        n         = 0;
        seen_low  = 1'b0;
        seen_done = 1'b0;
        while (!(seen_low && busy) && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done && !seen_done) begin
                seen_done = 1'b1;
                check("b2b_first_lat",   n,     8);
                check("b2b_first_equal", equal, 1);
            end
            if (!busy) seen_low = 1'b1;
        end
        check("b2b_restart_gap", n, 10);
        // operands now equal, but they were captured as FF/FE
        a_i   = 8'hFE;
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("b2b_second_lat",   lat,   LSB_LAT);
        check("b2b_second_equal", equal, 0);

        // asynchronous reset during the 4th SHIFT cycle
        wait_idle();
        start = 1'b1;
        a_i   = 8'hFF;
        b_i   = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_busy", busy, 1);
        check("pre_rst_eq_x", eq_x, 1);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_busy",  busy,  0);
        check("midrst_done",  done,  0);
        check("midrst_equal", equal, 0);
        check("midrst_eq_x",  eq_x,  0);
        check("midrst_eq_y",  eq_y,  0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) n++;
        end
        check("midrst_no_done", n, 0);
        run_cmp(8'h00, 8'h00, 8, 1'b1, 1'b0, "post_rst");

        // randomized comparisons
        for (int i = 0; i < 60; i++) begin
            av = W'($urandom);
            case ($urandom_range(0, 2))
                0:       bv = av;
                1:       bv = av ^ (W'(1) << $urandom_range(0, W - 1));
                default: bv = W'($urandom);
            endcase
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_cmp(av, bv, calc_lat(av, bv), (av == bv), 1'b1, "rnd");
        end

        wait_idle();
        repeat (2) @(negedge clk);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
